// File: rtl/bike_bram_serializer_pkg.sv
// Shared constants and types for the BIKE polynomial BRAM serializer.
// Provides ceiling division, the derived sizing helpers (wide words, sub-words
// per wide word, 32-bit output words, tail bits) and the serializer state enum.
package bike_bram_serializer_pkg;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_RUN  = 2'd1,
    SER_DONE = 2'd2
  } ser_state_e;

  // Ceiling of a/b for positive integers.
  function automatic int unsigned div_and_ceil(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Wide memory words holding the polynomial.
  function automatic int unsigned ser_num_words(input int unsigned r_bits, input int unsigned b_width);
    return div_and_ceil(r_bits, b_width);
  endfunction

  // 32-bit sub-words per wide memory word.
  function automatic int unsigned ser_subw(input int unsigned b_width);
    return b_width / 32;
  endfunction

  // 32-bit words in the output stream.
  function automatic int unsigned ser_num_out(input int unsigned r_bits);
    return div_and_ceil(r_bits, 32);
  endfunction

  // Valid bits in the final output word (0 means the word is full).
  function automatic int unsigned ser_tail(input int unsigned r_bits);
    return r_bits % 32;
  endfunction

endpackage

// File: rtl/bike_subword_select.sv
// Combinational 32-bit slice of a wide memory word, with optional tail masking.
// Ports:
//   word_i   - wide word to slice (B_WIDTH bits)
//   idx_i    - sub-word index, 0 selects bits 31:0
//   last_i   - slice is the final word of the polynomial
//   data_c_o - selected (and possibly masked) 32-bit word, combinational
// Build option: BIKE_SERIALIZER_TAIL_MASK_EN clears bits [31:TAIL] of the
// final word; without it the final word passes through unmodified.
module bike_subword_select
  import bike_bram_serializer_pkg::*;
#(
  parameter int unsigned B_WIDTH = 128,
  parameter int unsigned R_BITS  = 12323,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [B_WIDTH-1:0] word_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               last_i,
  output logic [31:0]        data_c_o
);

  localparam int unsigned SUBW = ser_subw(B_WIDTH);
  localparam int unsigned TAIL = ser_tail(R_BITS);

`ifdef BIKE_SERIALIZER_TAIL_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  localparam logic [31:0] TAIL_MASK = (TAIL == 0) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << TAIL) - 64'd1);

  // Sub-word mux followed by the tail mask.
  always_comb begin
    data_c_o = '0;
    for (int unsigned k = 0; k < SUBW; k++) begin
      if (idx_i == IDX_W'(k)) data_c_o = word_i[k*32 +: 32];
    end
    if (MASK_EN && last_i) data_c_o = data_c_o & TAIL_MASK;
  end

endmodule

// File: rtl/bike_bram_serializer.sv
// Read-side streamer: on start, reads wide words 0..NUM_WORDS-1 from the
// polynomial BRAM port and emits the R_BITS polynomial as 32-bit words,
// least-significant first, under valid/ready.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - one-cycle request (honoured only when idle)
//   busy, done          - transfer in progress / one-cycle completion pulse
//   mem_ren, mem_addr   - wide-port read request (data one cycle later)
//   mem_dout            - wide-port read data
//   m_data, m_valid,
//   m_ready, m_last     - 32-bit output stream
// Build option: BIKE_SERIALIZER_TAIL_MASK_EN masks unused bits of the last word.
module bike_bram_serializer
  import bike_bram_serializer_pkg::*;
#(
  parameter int unsigned B_WIDTH   = 128,
  parameter int unsigned R_BITS    = 12323,
  parameter int unsigned LOGSWORDS = $clog2(div_and_ceil(R_BITS, B_WIDTH))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_ren,
  output logic [LOGSWORDS-1:0] mem_addr,
  input  logic [B_WIDTH-1:0]   mem_dout,
  output logic [31:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  localparam int unsigned NUM_WORDS = ser_num_words(R_BITS, B_WIDTH);
  localparam int unsigned SUBW      = ser_subw(B_WIDTH);
  localparam int unsigned NUM_OUT   = ser_num_out(R_BITS);
  localparam int unsigned SUB_W     = (SUBW > 1) ? $clog2(SUBW) : 1;
  localparam int unsigned OUT_W     = $clog2(NUM_OUT + 1);
  localparam int unsigned RD_W      = $clog2(NUM_WORDS + 1);

  ser_state_e           state_q;
  logic                 busy_q, done_q;
  logic                 ren_q, ren_d;
  logic                 rvalid_q;
  logic [LOGSWORDS-1:0] addr_q, addr_d;
  logic [RD_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [B_WIDTH-1:0]   pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [B_WIDTH-1:0]   act_q, act_d;
  logic                 act_vld_q, act_vld_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [OUT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [31:0]          m_data_q;
  logic                 m_last_q;

  logic        hs, out_last, act_free, last_d;
  logic [31:0] sel_c;

  assign hs       = act_vld_q && m_ready;
  assign out_last = (out_cnt_q == OUT_W'(NUM_OUT - 1));
  // Active register is free if empty or its last emitted sub-word leaves now;
  // the final wide word ends early at the last output word.
  assign act_free = !act_vld_q || (hs && ((sub_q == SUB_W'(SUBW - 1)) || out_last));

  // Fetch engine and emission next-state.
  always_comb begin
    ren_d      = 1'b0;
    addr_d     = addr_q;
    rd_cnt_d   = rd_cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    act_vld_d  = act_vld_q;
    sub_d      = sub_q;
    out_cnt_d  = out_cnt_q;
    unique case (state_q)
      SER_IDLE: begin
        if (start) begin
          ren_d    = 1'b1;
          addr_d   = '0;
          rd_cnt_d = RD_W'(1);
        end
      end
      SER_RUN: begin
        if (hs) begin
          out_cnt_d = out_cnt_q + OUT_W'(1);
          sub_d     = sub_q + SUB_W'(1);
        end
        if (act_free) begin
          sub_d     = '0;
          act_vld_d = 1'b0;
          if (pend_vld_q) begin
            act_d      = pend_q;
            act_vld_d  = 1'b1;
            pend_vld_d = 1'b0;
          end else if (rvalid_q) begin
            act_d     = mem_dout;
            act_vld_d = 1'b1;
          end
        end
        // Returning data bypasses pending only when it can go straight to active.
        if (rvalid_q && !(act_free && !pend_vld_q)) begin
          pend_d     = mem_dout;
          pend_vld_d = 1'b1;
        end
        // Issue only when the returning word is guaranteed a free slot.
        if ((rd_cnt_q != RD_W'(NUM_WORDS)) && !ren_q && !pend_vld_d) begin
          ren_d    = 1'b1;
          addr_d   = LOGSWORDS'(rd_cnt_q);
          rd_cnt_d = rd_cnt_q + RD_W'(1);
        end
      end
      default: begin
        addr_d     = '0;
        rd_cnt_d   = '0;
        pend_vld_d = 1'b0;
        act_vld_d  = 1'b0;
        sub_d      = '0;
        out_cnt_d  = '0;
      end
    endcase
  end

  assign last_d = act_vld_d && (out_cnt_d == OUT_W'(NUM_OUT - 1));

  bike_subword_select #(
    .B_WIDTH(B_WIDTH),
    .R_BITS (R_BITS),
    .IDX_W  (SUB_W)
  ) u_sel (
    .word_i  (act_d),
    .idx_i   (sub_d),
    .last_i  (last_d),
    .data_c_o(sel_c)
  );

  // Control FSM plus all state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SER_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ren_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      act_vld_q  <= 1'b0;
      sub_q      <= '0;
      out_cnt_q  <= '0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      ren_q      <= ren_d;
      rvalid_q   <= ren_q;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
      act_vld_q  <= act_vld_d;
      sub_q      <= sub_d;
      out_cnt_q  <= out_cnt_d;
      m_data_q   <= act_vld_d ? sel_c : 32'h0;
      m_last_q   <= last_d;
      done_q     <= 1'b0;
      unique case (state_q)
        SER_IDLE: begin
          if (start) begin
            state_q <= SER_RUN;
            busy_q  <= 1'b1;
          end
        end
        SER_RUN: begin
          if (hs && out_last) begin
            state_q <= SER_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_ren  = ren_q;
  assign mem_addr = addr_q;
  assign m_data   = m_data_q;
  assign m_valid  = act_vld_q;
  assign m_last   = m_last_q;

endmodule

// File: tb/tb_bike_bram_serializer.sv
// Bench for bike_bram_serializer: a 128-bit and a 32-bit instance stream the
// same polynomial; a bench-side model predicts every output word, the read
// sequence, latency, gaps and the busy/done timing.
module tb_bike_bram_serializer;

  localparam int R_BITS = 12323;
  localparam int NOUT   = 386;

  logic clk;
  logic reset, start, m_ready;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]        poly [0:387];
  logic [127:0]       dout_a;
  logic [31:0]        dout_b;
  logic [6:0]         addr_a;
  logic [8:0]         addr_b;
  logic [1:0]         busy, done, ren, valid, last;
  logic [1:0][31:0]   data;

  bike_bram_serializer #(.B_WIDTH(128), .R_BITS(R_BITS)) dut_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .done(done[0]),
    .mem_ren(ren[0]), .mem_addr(addr_a), .mem_dout(dout_a),
    .m_data(data[0]), .m_valid(valid[0]), .m_ready(m_ready), .m_last(last[0]));

  bike_bram_serializer #(.B_WIDTH(32), .R_BITS(R_BITS)) dut_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .done(done[1]),
    .mem_ren(ren[1]), .mem_addr(addr_b), .mem_dout(dout_b),
    .m_data(data[1]), .m_valid(valid[1]), .m_ready(m_ready), .m_last(last[1]));

  // Memories: wide word k holds polynomial chunks 4k..4k+3 (chunk 0 in bits 31:0).
  always @(posedge clk) begin
    if (ren[0]) dout_a <= {poly[4*int'(addr_a)+3], poly[4*int'(addr_a)+2],
                           poly[4*int'(addr_a)+1], poly[4*int'(addr_a)]};
    if (ren[1]) dout_b <= poly[int'(addr_b)];
  end

  int  checks = 0, errors = 0;
  int  mst [2], cyc [2], widx [2], nrd [2], gap [2], done_cnt [2];
  bit  first_seen [2], go_done [2], stall_p [2];
  logic [31:0] prev_data [2];
  logic        prev_last [2];
  logic [31:0] cap [2][NOUT];
  bit  start_p = 1'b0, reset_p = 1'b0;
  bit  pat_phase = 1'b0, all_ready = 1'b0, tmo = 1'b0, tmo_seen = 1'b0;

  function automatic logic [31:0] exp_word(input int j);
    logic [31:0] w;
    w = poly[j];
`ifdef BIKE_SERIALIZER_TAIL_MASK_EN
    if (j == NOUT - 1) w = w & ((32'd1 << (R_BITS % 32)) - 32'd1);
`endif
    return w;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Single compare process; inputs seen at the previous negedge are the ones the
  // DUT sampled on the intervening rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int av;
      av = (d == 0) ? int'(addr_a) : int'(addr_b);
      if (reset_p) begin
        chk("reset_ctrl", d, 32'({busy[d], done[d], ren[d], valid[d], last[d]}), 32'd0);
        chk("reset_data", d, data[d], 32'd0);
        chk("reset_addr", d, 32'(av), 32'd0);
        mst[d] = 0; widx[d] = 0; nrd[d] = 0; gap[d] = 0;
        first_seen[d] = 1'b0; go_done[d] = 1'b0; stall_p[d] = 1'b0;
      end else begin
        if (mst[d] == 2) mst[d] = 0;
        else if (go_done[d]) mst[d] = 2;
        else if (mst[d] == 0 && start_p) begin
          mst[d] = 1; cyc[d] = 0; widx[d] = 0; nrd[d] = 0; gap[d] = 0; first_seen[d] = 1'b0;
        end
        go_done[d] = 1'b0;
        if (mst[d] == 1) cyc[d]++;
        chk("busy", d, 32'(busy[d]), 32'(mst[d] == 1));
        chk("done", d, 32'(done[d]), 32'(mst[d] == 2));
        if (mst[d] == 2) begin
          done_cnt[d]++;
          chk("read_count", d, 32'(nrd[d]), (d == 0) ? 32'd97 : 32'd386);
          chk("word_count", d, 32'(widx[d]), 32'(NOUT));
          if (pat_phase) begin
            chk("pin_w0", d, cap[d][0], 32'h0);
            chk("pin_w5", d, cap[d][5], 32'h1);
            chk("pin_w383", d, cap[d][383], 32'd95);
            chk("pin_w384", d, cap[d][384], 32'hFFFF_FFFF);
`ifdef BIKE_SERIALIZER_TAIL_MASK_EN
            chk("pin_tail", d, cap[d][385], 32'h0000_0007);
`else
            chk("pin_tail", d, cap[d][385], 32'hFFFF_FFFF);
`endif
          end
        end
        if (ren[d]) begin
          chk("ren_in_run", d, 32'(mst[d]), 32'd1);
          chk("read_addr", d, 32'(av), 32'(nrd[d]));
          nrd[d]++;
        end
        if (mst[d] == 1 && cyc[d] == 1) chk("first_ren", d, 32'(ren[d]), 32'd1);
        if (stall_p[d]) begin
          chk("stall_valid", d, 32'(valid[d]), 32'd1);
          chk("stall_data", d, data[d], prev_data[d]);
          chk("stall_last", d, 32'(last[d]), 32'(prev_last[d]));
        end
        if (valid[d]) begin
          if (!first_seen[d]) begin
            first_seen[d] = 1'b1;
            chk("first_valid_cycle", d, 32'(cyc[d]), 32'd3);
          end else if (gap[d] > 0 && all_ready) begin
            chk("gap", d, 32'(gap[d]), (d == 0) ? 32'd0 : 32'd1);
          end
          gap[d] = 0;
          if (m_ready) begin
            if (widx[d] >= NOUT) chk("extra_word", d, 32'(widx[d]), 32'(NOUT - 1));
            else begin
              chk("data", d, data[d], exp_word(widx[d]));
              chk("last", d, 32'(last[d]), 32'(widx[d] == NOUT - 1));
              cap[d][widx[d]] = data[d];
              if (widx[d] == NOUT - 1) go_done[d] = 1'b1;
            end
            widx[d]++;
          end
        end else if (first_seen[d] && mst[d] == 1) begin
          gap[d]++;
        end
        stall_p[d]   = valid[d] && !m_ready;
        prev_data[d] = data[d];
        prev_last[d] = last[d];
      end
    end
    if (tmo && !tmo_seen) begin
      tmo_seen = 1'b1;
      chk("timeout", 0, 32'd1, 32'd0);
    end
    start_p = start;
    reset_p = reset;
  end

  // Pulse start, drive m_ready until both instances report one more done.
  task automatic run_to_done(input bit rnd, input int extra_start);
    int t0, t1, n;
    t0 = done_cnt[0]; t1 = done_cnt[1]; n = 0;
    while ((done_cnt[0] == t0 || done_cnt[1] == t1) && n < 4000) begin
      @(posedge clk); #1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start   = (n == 0) || (n == extra_start);
      n++;
    end
    start = 1'b0; m_ready = 1'b1;
    if (n >= 4000) tmo = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mst[i] = 0; cyc[i] = 0; widx[i] = 0; nrd[i] = 0; gap[i] = 0; done_cnt[i] = 0;
    end
    for (int j = 0; j < 388; j++) poly[j] = (j >= 384) ? 32'hFFFF_FFFF : 32'(j / 4);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    pat_phase = 1'b1; all_ready = 1'b1;
    run_to_done(1'b0, -1);

    all_ready = 1'b0;
    run_to_done(1'b1, -1);

    pat_phase = 1'b0;
    for (int j = 0; j < 388; j++) poly[j] = $urandom;
    run_to_done(1'b1, 40);

    // Reset mid-transfer at output word 50 of the wide instance, then restart.
    all_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (widx[0] < 50 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) tmo = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_to_done(1'b0, -1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
